// File: rtl/sd_spi_pkg.sv
// Shared SD SPI-mode definitions: R1 masks, response modes, frame constants, responder states.
package sd_spi_pkg;

    localparam logic [7:0] R1_IDLE     = 8'h01;
    localparam logic [7:0] R1_ILLEGAL  = 8'h04;
    localparam logic [7:0] R1_CRC_ERR  = 8'h08;

    localparam logic [1:0] RESP_MODE_1B = 2'b00;
    localparam logic [1:0] RESP_MODE_2B = 2'b01;
    localparam logic [1:0] RESP_MODE_5B = 2'b10;

    localparam int unsigned FRAME_BITS = 48;
    localparam logic [6:0]  CRC7_POLY  = 7'h09;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_CMD,
        ST_CHECK,
        ST_WAIT_RESP,
        ST_NCR,
        ST_TX
    } resp_state_e;

    function automatic logic [5:0] resp_bits(input logic [1:0] mode);
        case (mode)
            RESP_MODE_1B: return 6'd8;
            RESP_MODE_2B: return 6'd16;
            default:      return 6'd40;
        endcase
    endfunction

    // Moves the right-aligned response so its first byte sits at the MSB end.
    function automatic logic [39:0] resp_align(input logic [1:0] mode, input logic [39:0] data);
        case (mode)
            RESP_MODE_1B: return {data[7:0], 32'h0};
            RESP_MODE_2B: return {data[15:0], 24'h0};
            default:      return data;
        endcase
    endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC-7 (x^7 + x^3 + 1), zero init; shared by the SD SPI responder and master.
module crc7_serial
    import sd_spi_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    logic [6:0] crc_q;
    logic       fb;

    assign fb  = din ^ crc_q[6];
    assign crc = crc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_q <= '0;
        end else if (clr) begin
            crc_q <= '0;
        end else if (en) begin
            crc_q <= {crc_q[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
        end
    end

endmodule

// File: rtl/spi_sd_responder.sv
// SPI-mode SD card responder: oversampled deframing of 48-bit commands, CRC-7 check,
// and a 1/2/5-byte MSB-first response after an Ncr gap of 0xFF bytes.
module spi_sd_responder
    import sd_spi_pkg::*;
#(
    parameter int unsigned NCR_MIN    = 1,
    parameter bit          CRC_CHECK  = 1'b1,
    parameter logic [7:0]  CRC_ERR_R1 = R1_IDLE | R1_CRC_ERR
) (
    input  logic        cpuClock,
    input  logic        reset,
    input  logic        SD_SCLK,
    input  logic        SD_MOSI,
    input  logic        SD_CS,
    output logic        SD_MISO,
    output logic        cmdValid,
    output logic        cmdTransmitBit,
    output logic [5:0]  cmdIndex,
    output logic [31:0] cmdArgument,
    output logic        cmdCrcOk,
    output logic        respReady,
    input  logic        respLoad,
    input  logic [1:0]  respMode,
    input  logic [39:0] respData,
    output logic        frameError,
    output logic        busy
);

    localparam logic [3:0] NCR_MIN_C = 4'(NCR_MIN);

    resp_state_e state_q, state_d;
    logic [2:0]  sclkSync_q;
    logic [1:0]  mosiSync_q, csSync_q;
    logic        rise, fall, mosi, csHigh;
    logic [5:0]  bitCnt_q, bitCnt_d;
    logic [46:0] frame_q, frame_d;
    logic [3:0]  byteCnt_q, byteCnt_d, bitInByte_q, bitInByte_d, byteInc;
    logic [5:0]  txCnt_q, txCnt_d, txLen_q, txLen_d, lenSrc;
    logic [39:0] txShift_q, txShift_d, shiftSrc;
    logic        miso_q, miso_d, cmdValid_q, cmdValid_d, frameErr_q, frameErr_d;
    logic        cmdT_q, cmdT_d, cmdCrcOk_q, cmdCrcOk_d;
    logic [5:0]  cmdIdx_q, cmdIdx_d;
    logic [31:0] cmdArg_q, cmdArg_d;
    logic        crcClr, crcEn, crcOk, respTaken;
    logic [6:0]  crcVal;

    assign rise   = sclkSync_q[1] & ~sclkSync_q[2];
    assign fall   = ~sclkSync_q[1] & sclkSync_q[2];
    assign mosi   = mosiSync_q[1];
    assign csHigh = csSync_q[1];
    assign crcOk  = (crcVal == frame_q[7:1]);

    crc7_serial u_crc (
        .clk (cpuClock),
        .rst (reset),
        .clr (crcClr),
        .en  (crcEn),
        .din (mosi),
        .crc (crcVal)
    );

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        frame_d     = frame_q;
        byteCnt_d   = byteCnt_q;
        bitInByte_d = bitInByte_q;
        txCnt_d     = txCnt_q;
        txLen_d     = txLen_q;
        txShift_d   = txShift_q;
        miso_d      = miso_q;
        cmdValid_d  = 1'b0;
        frameErr_d  = 1'b0;
        cmdT_d      = cmdT_q;
        cmdIdx_d    = cmdIdx_q;
        cmdArg_d    = cmdArg_q;
        cmdCrcOk_d  = cmdCrcOk_q;
        crcClr      = 1'b0;
        crcEn       = 1'b0;
        byteInc     = (byteCnt_q == 4'd8) ? 4'd8 : byteCnt_q + 4'd1;
        respTaken   = (state_q == ST_WAIT_RESP) && respLoad;
        shiftSrc    = respTaken ? resp_align(respMode, respData) : txShift_q;
        lenSrc      = respTaken ? resp_bits(respMode) : txLen_q;

        if (csHigh) begin
            state_d    = ST_IDLE;
            miso_d     = 1'b1;
            frameErr_d = (state_q == ST_RX_CMD);
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    miso_d = 1'b1;
                    crcClr = 1'b1;
                    if (rise && !mosi) begin
                        state_d  = ST_RX_CMD;
                        bitCnt_d = 6'd1;
                        frame_d  = '0;
                        crcClr   = 1'b0;
                        crcEn    = 1'b1;
                    end
                end
                ST_RX_CMD: begin
                    if (rise) begin
                        frame_d  = {frame_q[45:0], mosi};
                        bitCnt_d = bitCnt_q + 6'd1;
                        crcEn    = (bitCnt_q < 6'd40);
                        if (bitCnt_q == 6'd47) state_d = ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (!frame_q[0] || !frame_q[46]) begin
                        frameErr_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        cmdValid_d  = 1'b1;
                        cmdT_d      = frame_q[46];
                        cmdIdx_d    = frame_q[45:40];
                        cmdArg_d    = frame_q[39:8];
                        cmdCrcOk_d  = crcOk;
                        byteCnt_d   = '0;
                        bitInByte_d = '0;
                        if (CRC_CHECK && !crcOk) begin
                            txShift_d = {CRC_ERR_R1, 32'h0};
                            txLen_d   = 6'd8;
                            state_d   = ST_NCR;
                        end else begin
                            state_d = ST_WAIT_RESP;
                        end
                    end
                end
                ST_WAIT_RESP, ST_NCR: begin
                    miso_d = 1'b1;
                    if (respTaken) begin
                        txShift_d = shiftSrc;
                        txLen_d   = lenSrc;
                        state_d   = ST_NCR;
                    end
                    // A boundary is the fall that opens a new byte, after 8 full bits.
                    if (fall) begin
                        if (bitInByte_q == 4'd8) begin
                            bitInByte_d = 4'd1;
                            byteCnt_d   = byteInc;
                            if ((state_d == ST_NCR) && (byteInc >= NCR_MIN_C)) begin
                                miso_d    = shiftSrc[39];
                                txShift_d = {shiftSrc[38:0], 1'b0};
                                txLen_d   = lenSrc;
                                txCnt_d   = 6'd1;
                                state_d   = ST_TX;
                            end
                        end else begin
                            bitInByte_d = bitInByte_q + 4'd1;
                        end
                    end
                end
                ST_TX: begin
                    if (fall) begin
                        if (txCnt_q == txLen_q) begin
                            miso_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            miso_d    = txShift_q[39];
                            txShift_d = {txShift_q[38:0], 1'b0};
                            txCnt_d   = txCnt_q + 6'd1;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge cpuClock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sclkSync_q  <= '1;
            mosiSync_q  <= '1;
            csSync_q    <= '1;
            bitCnt_q    <= '0;
            frame_q     <= '0;
            byteCnt_q   <= '0;
            bitInByte_q <= '0;
            txCnt_q     <= '0;
            txLen_q     <= '0;
            txShift_q   <= '0;
            miso_q      <= 1'b1;
            cmdValid_q  <= 1'b0;
            frameErr_q  <= 1'b0;
            cmdT_q      <= 1'b0;
            cmdIdx_q    <= '0;
            cmdArg_q    <= '0;
            cmdCrcOk_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclkSync_q  <= {sclkSync_q[1:0], SD_SCLK};
            mosiSync_q  <= {mosiSync_q[0], SD_MOSI};
            csSync_q    <= {csSync_q[0], SD_CS};
            bitCnt_q    <= bitCnt_d;
            frame_q     <= frame_d;
            byteCnt_q   <= byteCnt_d;
            bitInByte_q <= bitInByte_d;
            txCnt_q     <= txCnt_d;
            txLen_q     <= txLen_d;
            txShift_q   <= txShift_d;
            miso_q      <= miso_d;
            cmdValid_q  <= cmdValid_d;
            frameErr_q  <= frameErr_d;
            cmdT_q      <= cmdT_d;
            cmdIdx_q    <= cmdIdx_d;
            cmdArg_q    <= cmdArg_d;
            cmdCrcOk_q  <= cmdCrcOk_d;
        end
    end

    assign SD_MISO        = miso_q;
    assign cmdValid       = cmdValid_q;
    assign cmdTransmitBit = cmdT_q;
    assign cmdIndex       = cmdIdx_q;
    assign cmdArgument    = cmdArg_q;
    assign cmdCrcOk       = cmdCrcOk_q;
    assign frameError     = frameErr_q;
    assign respReady      = (state_q == ST_WAIT_RESP);
    assign busy           = (state_q != ST_IDLE);

endmodule
